// File: rtl/initializer_conf_sender_if.sv
// Bundle of the configuration-sender signals: start request, config-memory read port,
// and the select-addressed configuration bus towards the GC modules.
//
// Handshake semantics: start is a one-cycle request, accepted only while busy=0;
// mem_rd_en/mem_addr request a read whose data is valid on mem_rdata the following
// cycle (no backpressure); conf_bus carries a word every cycle sel==SEL_ID, and the
// receiver answers the whole image with the level flag conf_ack.
interface initializer_conf_sender_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int SELECT_WIDTH = 3
);
  logic                    start;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic [DATA_WIDTH-1:0]   conf_bus;
  logic [SELECT_WIDTH-1:0] sel;
  logic                    conf_ack;
  logic                    busy;
  logic                    done;
  logic                    error;
  logic [7:0]              words_sent;

  modport master (
    input  start, base_addr, mem_rdata, conf_ack,
    output mem_rd_en, mem_addr, conf_bus, sel, busy, done, error, words_sent
  );

  modport slave (
    output start, base_addr, mem_rdata, conf_ack,
    input  mem_rd_en, mem_addr, conf_bus, sel, busy, done, error, words_sent
  );
endinterface

// File: rtl/initializer_conf_sender.sv
// Streams one initializer configuration image from config memory onto conf_bus/sel,
// then waits for the receiver's conf_ack (done) or gives up after a timeout (error).
module initializer_conf_sender #(
  parameter int                      DIMENSION                = 3,
  parameter int                      ITERATION_VARIABLE_WIDTH = 16,
  parameter int                      SELECT_WIDTH             = 3,
  parameter int                      PB_FILL                  = 5,
  parameter logic [SELECT_WIDTH-1:0] SEL_ID                   = 3'b010,
  parameter logic [SELECT_WIDTH-1:0] SEL_IDLE                 = 3'b000,
  parameter int                      ADDR_WIDTH               = 8,
  parameter int                      ACK_TIMEOUT              = 16
) (
  input  logic                       conf_clk,
  input  logic                       reset,
  initializer_conf_sender_if.master  cif,
  output logic [1:0]                 state_dbg
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int DW = ITERATION_VARIABLE_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRIME    = 2'd1,
    S_STREAM   = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [7:0]              total_q, total_d;
  logic [7:0]              words_q, words_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [DW-1:0]           bus_q, bus_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic                    error_q, error_d;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    done_c;

  // Number of init_ivar words: 1 plus the run of ones in output_selector from bit 1.
  function automatic logic [7:0] calc_niv(input logic [DIMENSION-1:0] os);
    logic [7:0] niv;
    logic       run;
    niv = 8'd1;
    run = 1'b1;
    for (int i = 1; i < DIMENSION; i++) begin
      if (run && os[i]) niv = niv + 8'd1;
      else              run = 1'b0;
    end
    return niv;
  endfunction

  always_ff @(posedge conf_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      total_q <= '0;
      words_q <= '0;
      timer_q <= '0;
      bus_q   <= '0;
      sel_q   <= SEL_IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      total_q <= total_d;
      words_q <= words_d;
      timer_q <= timer_d;
      bus_q   <= bus_d;
      sel_q   <= sel_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    total_d = total_q;
    words_d = words_q;
    timer_d = timer_q;
    bus_d   = bus_q;
    sel_d   = sel_q;
    error_d = error_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    done_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cif.start) begin
          rd_en   = 1'b1;
          rd_addr = cif.base_addr;
          base_d  = cif.base_addr;
          error_d = 1'b0;
          words_d = 8'd0;
          state_d = S_PRIME;
        end
      end

      // Word 0 is on mem_rdata here; it also sizes the rest of the image.
      S_PRIME: begin
        rd_en   = 1'b1;
        rd_addr = base_q + ADDR_WIDTH'(1);
        bus_d   = cif.mem_rdata;
        sel_d   = SEL_ID;
        total_d = 8'(4 + PB_FILL) + calc_niv(cif.mem_rdata[DIMENSION-1:0]);
        words_d = 8'd1;
        state_d = S_STREAM;
      end

      S_STREAM: begin
        if (words_q >= total_q) begin
          bus_d   = '0;
          sel_d   = SEL_IDLE;
          timer_d = '0;
          state_d = S_WAIT_ACK;
        end else begin
          bus_d   = cif.mem_rdata;
          words_d = (words_q == 8'hFF) ? words_q : words_q + 8'd1;
          // Read one word ahead, but never past the last image address.
          if (({1'b0, words_q} + 9'd1) < {1'b0, total_q}) begin
            rd_en   = 1'b1;
            rd_addr = base_q + ADDR_WIDTH'(words_q) + ADDR_WIDTH'(1);
          end
        end
      end

      S_WAIT_ACK: begin
        if (cif.conf_ack) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cif.mem_rd_en  = rd_en;
  assign cif.mem_addr   = rd_addr;
  assign cif.conf_bus   = bus_q;
  assign cif.sel        = sel_q;
  assign cif.busy       = (state_q != S_IDLE);
  assign cif.done       = done_c;
  assign cif.error      = error_q;
  assign cif.words_sent = words_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_initializer_conf_sender.sv
// Directed bench for initializer_conf_sender: config memory model, receiver model
// with selectable ack behaviour, expected-word queue and hand-computed timing checks.
module tb_initializer_conf_sender;

  localparam int         AW         = 8;
  localparam int         DW         = 16;
  localparam int         SW         = 3;
  localparam logic [2:0] SEL_ID     = 3'b010;
  localparam int         ACK_NEVER  = 0;
  localparam int         ACK_LATE   = 1;
  localparam int         ACK_ALWAYS = 2;

  // ---------------- clock / reset ----------------
  logic       conf_clk = 1'b0;
  logic       reset    = 1'b0;
  logic [1:0] state_dbg;

  always #5 conf_clk = ~conf_clk;

  initializer_conf_sender_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW)) cif();

  initializer_conf_sender dut (
    .conf_clk  (conf_clk),
    .reset     (reset),
    .cif       (cif),
    .state_dbg (state_dbg)
  );

  // ---------------- bench state ----------------
  logic [DW-1:0] mem [256];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_words[$];

  int n_checks, n_fail;
  int cyc, start_cyc, first_id, last_id, id_cnt, extra_words;
  int done_cnt, done_cyc, err_cyc, err_after_start;
  int rd_cnt, rd_min, rd_max, post_sel, post_bus;
  int rx_since, ack_mode;
  bit rx_active, repulse_done, done_now;

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic update_ack();
    case (ack_mode)
      ACK_NEVER:  cif.conf_ack = 1'b0;
      ACK_ALWAYS: cif.conf_ack = 1'b1;
      default:    cif.conf_ack = rx_active && (rx_since >= 2);
    endcase
  endtask

  // One clock cycle: observe at the falling edge, then let memory and receiver react.
  task automatic step();
    logic [2:0]    o_sel;
    logic [DW-1:0] o_bus;
    logic          re;
    logic [AW-1:0] ra;
    @(negedge conf_clk);
    o_sel = cif.sel;
    o_bus = cif.conf_bus;
    re    = cif.mem_rd_en;
    ra    = cif.mem_addr;
    done_now = 1'b0;
    if (re) begin
      rd_cnt++;
      if (int'(ra) < rd_min) rd_min = int'(ra);
      if (int'(ra) > rd_max) rd_max = int'(ra);
    end
    if (last_id >= 0 && cyc == last_id + 1) begin
      post_sel = int'(o_sel);
      post_bus = int'(o_bus);
    end
    if (o_sel == SEL_ID) begin
      id_cnt++;
      if (first_id < 0) first_id = cyc;
      last_id = cyc;
      if (exp_q.size() > 0) check_eq("conf_bus_word", o_bus, exp_q.pop_front());
      else extra_words++;
    end
    if (cif.done) begin
      done_cnt++;
      done_cyc = cyc;
      done_now = 1'b1;
      if (repulse_done) cif.start = 1'b1;
    end
    if (cif.error && cyc > start_cyc && err_cyc < 0) err_cyc = cyc;
    @(posedge conf_clk);
    #1;
    if (re) cif.mem_rdata = mem[ra];
    if (o_sel == SEL_ID) begin
      rx_words.push_back(o_bus);
      rx_active = 1'b1;
      rx_since  = 0;
    end else if (rx_active) begin
      rx_since++;
    end
    update_ack();
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_std(input int base, input logic [DW-1:0] w0);
    logic [DW-1:0] img [12];
    img = '{w0, 16'h0005, 16'h0001, 16'h0FFF, 16'h0000, 16'h0000, 16'h0000,
            16'h0000, 16'h0007, 16'h0010, 16'h0020, 16'h0030};
    for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
    for (int i = 0; i < 12; i++) mem[(base + i) % 256] = img[i];
  endtask

  task automatic begin_image(input int base, input int total, input int mode, input bit rep);
    exp_q.delete();
    for (int i = 0; i < total; i++) exp_q.push_back(mem[(base + i) % 256]);
    rx_words.delete();
    first_id = -1; last_id = -1; id_cnt = 0; extra_words = 0;
    done_cnt = 0; done_cyc = -1; err_cyc = -1;
    rd_cnt = 0; rd_min = 9999; rd_max = -1; post_sel = -1; post_bus = -1;
    ack_mode = mode; rx_active = 1'b0; rx_since = 0; repulse_done = rep;
    update_ack();
    cif.base_addr = AW'(base);
    cif.start     = 1'b1;
    start_cyc     = cyc;
    step();
    cif.start     = 1'b0;
    cif.base_addr = 8'hA5;
    err_after_start = int'(cif.error);
  endtask

  task automatic finish_image(input bit rep);
    for (int n = 0; n < 60; n++) begin
      if (rep && n == 4) begin
        cif.start     = 1'b1;
        cif.base_addr = 8'h33;
      end
      step();
      cif.start = 1'b0;
      if (done_now || err_cyc >= 0) break;
    end
    check_eq("run_bounded", (done_cnt > 0 || err_cyc >= 0), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; start_cyc = 0;
    first_id = -1; last_id = -1; err_cyc = -1;
    ack_mode = ACK_NEVER; rx_active = 1'b0; rx_since = 0; repulse_done = 1'b0;
    cif.start = 1'b0; cif.base_addr = '0; cif.mem_rdata = '0; cif.conf_ack = 1'b0;
    load_std(0, 16'h0007);

    repeat (3) @(negedge conf_clk);
    check_eq("rst_sel", cif.sel, 3'b000);
    check_eq("rst_conf_bus", cif.conf_bus, 16'h0000);
    check_eq("rst_busy", cif.busy, 1'b0);
    check_eq("rst_done", cif.done, 1'b0);
    check_eq("rst_error", cif.error, 1'b0);
    check_eq("rst_words_sent", cif.words_sent, 8'd0);
    check_eq("rst_rd_en", cif.mem_rd_en, 1'b0);
    check_eq("rst_state", state_dbg, 2'd0);
    reset = 1'b1;
    repeat (2) step();

    // Full image, os=3'b111 -> NIV 3, TOTAL 12.
    load_std(0, 16'h0007);
    begin_image(0, 12, ACK_LATE, 1'b0);
    finish_image(1'b0);
    check_eq("t1_id_cycles", id_cnt, 12);
    check_eq("t1_no_bubbles", last_id - first_id + 1, 12);
    check_eq("t1_extra_words", extra_words, 0);
    check_eq("t1_first_word_lat", first_id - start_cyc, 2);
    check_eq("t1_done_lat", done_cyc - first_id, 14);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_words_sent", cif.words_sent, 8'd12);
    check_eq("t1_rd_cnt", rd_cnt, 12);
    check_eq("t1_rd_min", rd_min, 0);
    check_eq("t1_rd_max", rd_max, 11);
    check_eq("t1_post_sel", post_sel, 0);
    check_eq("t1_post_bus", post_bus, 0);
    check_eq("t1_busy_after", cif.busy, 1'b0);
    step();
    check_eq("t1_words_hold", cif.words_sent, 8'd12);

    // os=3'b101 -> NIV 1, TOTAL 10, address 10 must stay unread.
    load_std(0, 16'h0005);
    begin_image(0, 10, ACK_LATE, 1'b0);
    finish_image(1'b0);
    check_eq("t2_id_cycles", id_cnt, 10);
    check_eq("t2_rd_cnt", rd_cnt, 10);
    check_eq("t2_rd_max", rd_max, 9);
    check_eq("t2_words_sent", cif.words_sent, 8'd10);
    check_eq("t2_done_cnt", done_cnt, 1);
    if (rx_words.size() > 9) check_eq("t2_rx_init_ivar0", rx_words[9], 16'h0010);
    else check_eq("t2_rx_len", rx_words.size(), 10);

    // os=3'b011 -> NIV 2, TOTAL 11, image at 0x40.
    load_std(8'h40, 16'h0003);
    begin_image(8'h40, 11, ACK_LATE, 1'b0);
    finish_image(1'b0);
    check_eq("t3_rd_min", rd_min, 8'h40);
    check_eq("t3_rd_max", rd_max, 8'h4A);
    check_eq("t3_rd_cnt", rd_cnt, 11);
    check_eq("t3_id_cycles", id_cnt, 11);
    check_eq("t3_words_sent", cif.words_sent, 8'd11);
    check_eq("t3_post_sel", post_sel, 0);
    check_eq("t3_post_bus", post_bus, 0);

    // Receiver never acks -> error 16 cycles after entering WAIT_ACK.
    load_std(0, 16'h0007);
    begin_image(0, 12, ACK_NEVER, 1'b0);
    finish_image(1'b0);
    check_eq("t4_err_lat", err_cyc - (last_id + 1), 16);
    check_eq("t4_done_cnt", done_cnt, 0);
    check_eq("t4_busy", cif.busy, 1'b0);
    check_eq("t4_error_sticky", cif.error, 1'b1);
    check_eq("t4_id_cycles", id_cnt, 12);

    // Reset during the 4th streamed word, then a clean resend.
    begin_image(0, 12, ACK_LATE, 1'b0);
    check_eq("t5_error_cleared", err_after_start, 0);
    for (int n = 0; n < 10 && id_cnt < 3; n++) step();
    check_eq("t5_word3_on_bus", cif.conf_bus, 16'h0FFF);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_sel", cif.sel, 3'b000);
    check_eq("t5_rst_bus", cif.conf_bus, 16'h0000);
    check_eq("t5_rst_busy", cif.busy, 1'b0);
    check_eq("t5_rst_words", cif.words_sent, 8'd0);
    @(negedge conf_clk);
    reset = 1'b1;
    step();
    begin_image(0, 12, ACK_LATE, 1'b0);
    finish_image(1'b0);
    check_eq("t5_id_cycles", id_cnt, 12);
    check_eq("t5_extra_words", extra_words, 0);
    check_eq("t5_done_cnt", done_cnt, 1);
    check_eq("t5_rd_min", rd_min, 0);

    // start re-pulsed mid-stream and in the done cycle: no effect.
    begin_image(0, 12, ACK_LATE, 1'b1);
    finish_image(1'b1);
    check_eq("t6_id_cycles", id_cnt, 12);
    check_eq("t6_extra_words", extra_words, 0);
    check_eq("t6_rd_cnt", rd_cnt, 12);
    check_eq("t6_rd_max", rd_max, 11);
    check_eq("t6_rd_min", rd_min, 0);
    check_eq("t6_words_sent", cif.words_sent, 8'd12);
    check_eq("t6_busy_after_done", cif.busy, 1'b0);
    check_eq("t6_state_idle", state_dbg, 2'd0);

    // conf_ack already high: stream anyway, done in the first WAIT_ACK cycle.
    begin_image(0, 12, ACK_ALWAYS, 1'b0);
    finish_image(1'b0);
    check_eq("t7_id_cycles", id_cnt, 12);
    check_eq("t7_done_first_wait", done_cyc, last_id + 1);
    check_eq("t7_done_cnt", done_cnt, 1);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/initializer_conf_sender.md
Name: initializer_conf_sender

Overview:
- Transmit end of the global-controller configuration protocol for the initializer (select id 2).
- On a start pulse, fetches a configuration image from a word-addressed config memory and drives it onto conf_bus/sel at one word per cycle.
- After the last word, waits for conf_ack and reports done, or reports error on timeout.
- Sits in the configuration manager, ahead of the initializer and the other select-addressed GC modules.

Parameters:
DIMENSION, 3, number of iteration variables supported by the receiver
ITERATION_VARIABLE_WIDTH, 16, conf_bus / config memory word width
SELECT_WIDTH, 3, width of sel
PB_FILL, 5, number of pb_selector words in the image
SEL_ID, 3'b010, sel value driven while streaming
SEL_IDLE, 3'b000, sel value driven when not streaming
ADDR_WIDTH, 8, config memory address width
ACK_TIMEOUT, 16, cycles to wait for conf_ack after the last word

Ports:
conf_clk  in  1  configuration clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle request to send one image; ignored while busy
base_addr  in  ADDR_WIDTH  address of word 0, sampled with start
mem_rd_en  out  1  config memory read strobe
mem_addr  out  ADDR_WIDTH  config memory read address
mem_rdata  in  ITERATION_VARIABLE_WIDTH  read data, valid the cycle after mem_rd_en
conf_bus  out  ITERATION_VARIABLE_WIDTH  configuration word to the receiver
sel  out  SELECT_WIDTH  module select
conf_ack  in  1  receiver's load-complete flag
busy  out  1  high from the start edge until done or error
done  out  1  one-cycle pulse on successful ack
error  out  1  sticky timeout flag, cleared by the next accepted start
words_sent  out  8  count of words driven in the current or last image

Behaviour:
- Reset (reset=0, async): all outputs 0 except sel=SEL_IDLE; FSM to IDLE; counters cleared.
- Image order:
  - word 0: output_selector (low DIMENSION bits used).
  - word 1: init_ic.
  - word 2: restart_mode.
  - words 3..3+PB_FILL-1: pb_selector, LSW first.
  - word 3+PB_FILL: ic_selector.
  - then NIV init_ivar words, index 0 first.
- NIV = 1 + length of the contiguous run of 1s in output_selector starting at bit 1, capped at DIMENSION.
  - Examples for DIMENSION=3: os=3'b111 gives NIV 3; os=3'b011 gives 2; os=3'b101 gives 1; os=3'b000 gives 1.
- TOTAL = 4 + PB_FILL + NIV words. NIV is computed when word 0 returns from memory.
- FSM:
  - IDLE:
    - start=1 → latch base_addr, mem_rd_en=1, mem_addr=base, clear error and words_sent, busy=1 → PRIME.
  - PRIME (rdata0 valid):
    - Issue addr base+1.
    - At the edge: conf_bus<=rdata0, sel<=SEL_ID, compute TOTAL, words_sent<=1 → STREAM.
  - STREAM:
    - Each cycle register mem_rdata onto conf_bus with sel=SEL_ID, and words_sent+1.
    - Reads are issued only for addresses < base+TOTAL; no over-read beyond base+TOTAL-1.
    - When the word driven is number TOTAL-1 (the last), next edge: sel<=SEL_IDLE, conf_bus<=0 → WAIT_ACK with timer=0.
  - WAIT_ACK:
    - conf_ack=1 → done=1 for one cycle, busy<=0 → IDLE.
    - Otherwise timer+1; when timer reaches ACK_TIMEOUT-1 without ack → error<=1, busy<=0 → IDLE.
- Timing:
  - Exactly TOTAL consecutive cycles with sel=SEL_ID, no bubbles.
  - First conf_bus word appears 2 cycles after the start edge.
- Receiver handshake:
  - conf_ack rising on the edge that consumes the last word is seen in WAIT_ACK's first cycle.
  - For a compliant receiver, done occurs TOTAL+2 cycles after the first word.
- conf_ack already 1 at start (receiver not reset): stream anyway; done in the first WAIT_ACK cycle.
- start while busy: ignored; no effect on address or counters.
- start in the same cycle as done: ignored (FSM not yet IDLE).
- words_sent saturates at 255 and holds its value after done/error until the next start.
- Reset mid-stream: immediate return to reset values; sel=SEL_IDLE the same instant.

Test Plan:
- Mem[0..]= 0x0007, 0x0005, 0x0001, 5 pb words 0x0FFF,0,0,0,0, 0x0007, 0x0010, 0x0020, 0x0030; start with base 0; receiver model acks → sel=2 for exactly 12 cycles, conf_bus sequence identical, done 14 cycles after first word, words_sent=12.
- Word 0 = 0x0005 (os=3'b101) → TOTAL=10; no read of address base+10; receiver model's init_ivar[0] = word 9.
- Word 0 = 0x0003 with base_addr=0x40 → reads 0x40..0x4A only, 11 words driven, sel back to 0 after the last word.
- Receiver held in reset (conf_ack=0) → after the stream, error=1 ACK_TIMEOUT cycles after entering WAIT_ACK, busy=0, done never asserted; a following start clears error.
- Reset pulsed low during the 4th streamed word → sel=0, conf_bus=0, busy=0 immediately; a new start resends the full image from word 0.
- start re-pulsed in mid-stream and in the done cycle → no change to mem_addr, words_sent, or sequence.
